// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module   : lsu_pkg
//  Desc     : Shared encodings, FSM states and helpers for the load/store unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough for the largest legal ACK_TIMEOUT (255).
    localparam int C_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } lsu_state_t;

    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module   : lsu_align
//  Desc     : Combinational load lane extraction/extension and store lane merge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;
    logic [31:0] w_wrep;

    always_comb begin
        w_byte = rword[7:0];
        case (byte_off)
            2'd0:    w_byte = rword[7:0];
            2'd1:    w_byte = rword[15:8];
            2'd2:    w_byte = rword[23:16];
            default: w_byte = rword[31:24];
        endcase
        w_half = byte_off[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        load_data = rword;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: load_data = is_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: load_data = rword;
        endcase
    end

    // Replicate the store data across every lane, then let the mask pick one.
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        w_wrep = wdata;
        case (size)
            SZ_BYTE: begin
                w_mask = 32'h0000_00FF << {byte_off, 3'b000};
                w_wrep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                w_mask = byte_off[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                w_wrep = {2{wdata[15:0]}};
            end
            default: begin
                w_mask = 32'hFFFF_FFFF;
                w_wrep = wdata;
            end
        endcase
        store_word = (rword & ~w_mask) | (w_wrep & w_mask);
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module   : load_store_unit
//  Desc     : Memory bus initiator for byte/half/word loads and stores with
//             read-modify-write sub-word stores and an ack timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(ACK_TIMEOUT - 1);

    lsu_state_t         r_state;
    lsu_state_t         w_next_state;
    logic               w_timeout;

    logic               r_we;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_mem_data;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [C_CNT_W-1:0] r_cnt;

    logic [31:0]        w_load_data;
    logic [31:0]        w_store_word;

    lsu_align u_align (
        .size        (r_size),
        .is_unsigned (r_uns),
        .byte_off    (r_addr[1:0]),
        .rword       (mem_data_i),
        .wdata       (r_wdata),
        .load_data   (w_load_data),
        .store_word  (w_store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    if (access_bad(size_i, addr_i[1:0])) begin
                        w_next_state = ST_DONE;
                    end else if (we_i && (size_i == SZ_WORD)) begin
                        w_next_state = ST_WR;
                    end else begin
                        w_next_state = ST_RD;
                    end
                end
            end
            ST_RD: w_next_state = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (mem_ack_i) begin
                    w_next_state = r_we ? ST_WR : ST_DONE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_next_state = ST_DONE;
                    w_timeout    = 1'b1;
                end
            end
            ST_WR: w_next_state = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (mem_ack_i) begin
                    w_next_state = ST_DONE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_next_state = ST_DONE;
                    w_timeout    = 1'b1;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request fields, timeout counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_uns      <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_mem_data <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_i) begin
                        r_we    <= we_i;
                        r_size  <= size_i;
                        r_uns   <= unsigned_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_err   <= access_bad(size_i, addr_i[1:0]);
                        if (we_i) begin
                            r_mem_data <= wdata_i;
                        end
                    end
                end
                ST_RD, ST_WR: begin
                    r_cnt <= '0;
                end
                ST_RD_WAIT: begin
                    if (mem_ack_i) begin
                        if (r_we) begin
                            r_mem_data <= w_store_word;
                        end else begin
                            r_rdata <= w_load_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (!mem_ack_i) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = (r_state == ST_DONE);
    assign err_o       = (r_state == ST_DONE) && r_err;
    assign rdata_o     = r_rdata;
    assign mem_rd_en_o = (r_state == ST_RD);
    assign mem_wr_en_o = (r_state == ST_WR);
    assign mem_addr_o  = {r_addr[31:2], 2'b00};
    assign mem_data_o  = r_mem_data;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module   : tb_load_store_unit
//  Desc     : Self-checking bench for load_store_unit with a one-cycle memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ACK_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .we_i        (we),
        .size_i      (size),
        .unsigned_i  (uns),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .rdata_o     (rdata),
        .mem_rd_en_o (mem_rd_en),
        .mem_wr_en_o (mem_wr_en),
        .mem_addr_o  (mem_addr),
        .mem_data_o  (mem_wdata),
        .mem_data_i  (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    // Memory responder: acks in the cycle right after a request.
    logic [31:0] mem [0:15];
    logic        ack_r = 1'b0;
    logic        no_ack = 1'b0;
    logic        stray_ack = 1'b0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          overlap = 0;

    always @(posedge clk) begin
        ack_r <= 1'b0;
        if (mem_rd_en && mem_wr_en) overlap++;
        if (mem_rd_en) begin
            rd_count++;
            if (!no_ack) begin
                ack_r     <= 1'b1;
                mem_rdata <= mem[mem_addr[5:2]];
            end
        end
        if (mem_wr_en) begin
            wr_count++;
            mem[mem_addr[5:2]] <= mem_wdata;
            if (!no_ack) ack_r <= 1'b1;
        end
    end
    assign mem_ack = ack_r | stray_ack;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cycles;
        int          exp_rd;
        int          exp_wr;
        logic        chk_mem;
        logic [31:0] mem_addr;
        logic [31:0] mem_word;
    } vec_t;

    vec_t vecs [16];
    vec_t sb [$];

    function automatic vec_t mk(input logic w, input logic [1:0] s, input logic u,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] er, input logic ee, input int cyc,
                                input int nrd, input int nwr, input logic cm,
                                input logic [31:0] ma, input logic [31:0] mw);
        vec_t v;
        v.we = w; v.size = s; v.uns = u; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_err = ee; v.exp_cycles = cyc;
        v.exp_rd = nrd; v.exp_wr = nwr; v.chk_mem = cm; v.mem_addr = ma; v.mem_word = mw;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_rdata);
        check32({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check32({tag, "_done"}, {31'd0, done}, 32'd0);
        check32({tag, "_err"}, {31'd0, err}, 32'd0);
        check32({tag, "_rdata"}, rdata, exp_rdata);
        check32({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
        check32({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
    endtask

    task automatic run_txn(input string tag, input vec_t v, input bit hold);
        int   rd0, wr0, n;
        logic got;
        vec_t e;
        @(negedge clk);
        req = 1'b1; we = v.we; size = v.size; uns = v.uns; addr = v.addr; wdata = v.wdata;
        sb.push_back(v);
        rd0 = rd_count;
        wr0 = wr_count;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
        req = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got no done expected done within 40 cycles", tag);
            sb.delete();
        end else begin
            e = sb.pop_front();
            check32({tag, "_err"}, {31'd0, err}, {31'd0, e.exp_err});
            check32({tag, "_rdata"}, rdata, e.exp_rdata);
            check32({tag, "_latency"}, 32'(n), 32'(e.exp_cycles));
            check32({tag, "_reads"}, 32'(rd_count - rd0), 32'(e.exp_rd));
            check32({tag, "_writes"}, 32'(wr_count - wr0), 32'(e.exp_wr));
            if (e.chk_mem) check32({tag, "_mem"}, mem[e.mem_addr[5:2]], e.mem_word);
            @(negedge clk);
            check32({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[4] = 32'h8877_6655;

        vecs[0]  = mk(0, SZ_BYTE, 0, 32'h13, 32'h0,         32'hFFFF_FF88, 0, 3, 1, 0, 0, 0, 0);
        vecs[1]  = mk(0, SZ_BYTE, 1, 32'h13, 32'h0,         32'h0000_0088, 0, 3, 1, 0, 0, 0, 0);
        vecs[2]  = mk(0, SZ_HALF, 0, 32'h12, 32'h0,         32'hFFFF_8877, 0, 3, 1, 0, 0, 0, 0);
        vecs[3]  = mk(0, SZ_HALF, 1, 32'h10, 32'h0,         32'h0000_6655, 0, 3, 1, 0, 0, 0, 0);
        vecs[4]  = mk(1, SZ_BYTE, 0, 32'h11, 32'h0000_00AB, 32'h0000_6655, 0, 5, 1, 1, 1, 32'h10, 32'h8877_AB55);
        vecs[5]  = mk(1, SZ_WORD, 0, 32'h20, 32'hDEAD_BEEF, 32'h0000_6655, 0, 3, 0, 1, 1, 32'h20, 32'hDEAD_BEEF);
        vecs[6]  = mk(0, SZ_WORD, 0, 32'h20, 32'h0,         32'hDEAD_BEEF, 0, 3, 1, 0, 0, 0, 0);
        vecs[7]  = mk(0, SZ_HALF, 0, 32'h21, 32'h0,         32'hDEAD_BEEF, 1, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, SZ_WORD, 0, 32'h22, 32'h0,         32'hDEAD_BEEF, 1, 1, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 2'b11,   0, 32'h20, 32'h0,         32'hDEAD_BEEF, 1, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, SZ_HALF, 0, 32'h12, 32'hFFFF_1234, 32'hDEAD_BEEF, 0, 5, 1, 1, 1, 32'h10, 32'h1234_AB55);
        vecs[11] = mk(0, SZ_BYTE, 0, 32'h11, 32'h0,         32'hFFFF_FFAB, 0, 3, 1, 0, 0, 0, 0);
        vecs[12] = mk(1, SZ_BYTE, 0, 32'h13, 32'hFFFF_FF7F, 32'hFFFF_FFAB, 0, 5, 1, 1, 1, 32'h10, 32'h7F34_AB55);
        vecs[13] = mk(0, SZ_BYTE, 0, 32'h13, 32'h0,         32'h0000_007F, 0, 3, 1, 0, 0, 0, 0);
        vecs[14] = mk(0, SZ_HALF, 0, 32'h12, 32'h0,         32'h0000_7F34, 0, 3, 1, 0, 0, 0, 0);
        vecs[15] = mk(1, SZ_HALF, 0, 32'h13, 32'h0000_5555, 32'h0000_7F34, 1, 1, 0, 0, 1, 32'h10, 32'h7F34_AB55);

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset", 32'd0);
        check32("reset_addr", mem_addr, 32'd0);
        check32("reset_data", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_txn($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Missing ack on a load, then on a word store.
        no_ack = 1'b1;
        run_txn("timeout_ld", mk(0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h0000_7F34, 1, 6, 1, 0, 0, 0, 0), 1'b0);
        run_txn("timeout_st", mk(1, SZ_WORD, 0, 32'h24, 32'h1111_2222, 32'h0000_7F34, 1, 6, 0, 1, 0, 0, 0), 1'b0);
        no_ack = 1'b0;
        run_txn("after_timeout", mk(0, SZ_WORD, 0, 32'h20, 32'h0, 32'hDEAD_BEEF, 0, 3, 1, 0, 0, 0, 0), 1'b0);

        // req_i held high through the whole transaction must start only one access.
        run_txn("held_req", mk(0, SZ_WORD, 0, 32'h10, 32'h0, 32'h7F34_AB55, 0, 3, 1, 0, 0, 0, 0), 1'b1);

        // Stray ack while idle.
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        check_idle_outputs("stray_ack", 32'h7F34_AB55);
        run_txn("after_stray", mk(0, SZ_HALF, 1, 32'h10, 32'h0, 32'h0000_AB55, 0, 3, 1, 0, 0, 0, 0), 1'b0);

        // Asynchronous reset while waiting for a read ack.
        @(negedge clk);
        no_ack = 1'b1;
        req = 1'b1; we = 1'b0; size = SZ_WORD; uns = 1'b0; addr = 32'h20;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        check32("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset", 32'd0);
        check32("midreset_addr", mem_addr, 32'd0);
        check32("midreset_data", mem_wdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check32("midreset_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        no_ack = 1'b0;
        run_txn("after_reset", mk(0, SZ_WORD, 0, 32'h20, 32'h0, 32'hDEAD_BEEF, 0, 3, 1, 0, 0, 0, 0), 1'b0);

        check32("rd_wr_overlap", 32'(overlap), 32'd0);
        check32("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
